// File: rtl/mult_add_pkg.sv
// Shared types and width helpers for the sequential multiply-add unit.
package mult_add_pkg;

    // Control states: wait for start, shift-add one bit per clock, pulse done.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the bit counter, which runs 0..w-1.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/mult_add_if.sv
// Handshake and operand bus of the sequential multiply-add unit.
// Handshake: the master raises start with Q_in/B_in/R_in valid; the unit
// accepts only while busy is low (IDLE), latches the operands on that edge and
// raises busy. Once busy is high, start and the operand inputs are ignored.
// When the result is ready, done pulses for exactly one cycle with P valid.
// P then holds its value until the next accepted start.
import mult_add_pkg::*;

interface mult_add_if #(
    parameter int W = 7
);
    logic           start;
    logic [W-1:0]   Q_in;
    logic [W-1:0]   B_in;
    logic [W-1:0]   R_in;
    logic [2*W-1:0] P;
    logic           busy;
    logic           done;
    state_e         state_dbg;

    modport master (
        output start, Q_in, B_in, R_in,
        input  P, busy, done, state_dbg
    );

    modport slave (
        input  start, Q_in, B_in, R_in,
        output P, busy, done, state_dbg
    );
endinterface

// File: rtl/mult_add_secuencial.sv
// Sequential shift-add multiplier-accumulator: P = Q*B + R.
// One multiplier bit is consumed per clock; the run length is always W cycles,
// independent of the operand values.
import mult_add_pkg::*;

module mult_add_secuencial #(
    parameter int W = 7
) (
    input  logic       clk,
    input  logic       rst,
    mult_add_if.slave  bus
);

    localparam int CNT_W = cnt_width(W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

    state_e           state_q;
    logic [W-1:0]     q_q;
    logic [2*W-1:0]   b_sh_q;
    logic [2*W-1:0]   acc_q;
    logic [2*W-1:0]   acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2*W-1:0]   p_q;
    logic             busy_q;
    logic             done_q;

    // Conditional add of the shifted multiplicand for the current multiplier bit.
    // The result fits in 2W bits for all operands, so no carry-out is kept.
    always_comb begin
        acc_d = acc_q;
        if (q_q[0]) begin
            acc_d = acc_q + b_sh_q;
        end
    end

    // Control FSM and datapath registers; outputs are registered here too.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        q_q     <= bus.Q_in;
                        b_sh_q  <= {{W{1'b0}}, bus.B_in};
                        acc_q   <= {{W{1'b0}}, bus.R_in};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q  <= acc_d;
                    b_sh_q <= b_sh_q << 1;
                    q_q    <= q_q >> 1;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        p_q     <= acc_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.P         = p_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mult_add_secuencial.sv
// Self-checking bench for mult_add_secuencial (W = 7).
module tb_mult_add_secuencial;
    import mult_add_pkg::*;

    localparam int W  = 7;
    localparam int PW = 2 * W;

    // Clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_add_if #(.W(W)) bus();

    mult_add_secuencial #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0]  q;
        logic [W-1:0]  b;
        logic [W-1:0]  r;
        logic [PW-1:0] exp;
    } vec_t;

    vec_t           vecs[5];
    vec_t           b2b[3];
    logic [PW-1:0]  exp_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;
    int             done_cnt = 0;
    time            accept_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result
    always @(negedge clk) begin
        logic [PW-1:0] e;
        if (bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("P_result", 32'(bus.P), 32'(e));
            end
        end
    end

    // Driver: present operands with start, wait until the unit is idle, and
    // return just after the accepting edge.
    task automatic launch(input logic [W-1:0] q, input logic [W-1:0] b,
                          input logic [W-1:0] r, input logic [PW-1:0] e,
                          input bit hold);
        int guard = 0;
        bus.Q_in  = q;
        bus.B_in  = b;
        bus.R_in  = r;
        bus.start = 1'b1;
        while (bus.busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            check("accept_timeout", 32'd1, 32'd0);
            bus.start = 1'b0;
        end else begin
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            accept_t = $time;
            if (!hold) bus.start = 1'b0;
        end
    endtask

    // Count edges from the accepting edge to the edge that raised done.
    task automatic wait_done(output int lat);
        bit ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int lat;
        int dc;
        time prev_t;
        int a;
        int bb;

        vecs[0] = '{7'd7,   7'd7,   7'd1,   14'd50};
        vecs[1] = '{7'd127, 7'd127, 7'd126, 14'd16255};
        vecs[2] = '{7'd0,   7'd99,  7'd42,  14'd42};
        vecs[3] = '{7'd55,  7'd0,   7'd3,   14'd3};
        vecs[4] = '{7'd127, 7'd127, 7'd127, 14'd16256};
        b2b[0]  = '{7'd7,   7'd5,   7'd0,   14'd35};
        b2b[1]  = '{7'd7,   7'd8,   7'd7,   14'd63};
        b2b[2]  = '{7'd6,   7'd15,  7'd10,  14'd100};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.Q_in  = '0;
        bus.B_in  = '0;
        bus.R_in  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_P",     32'(bus.P), 32'd0);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_done",  32'(bus.done), 32'd0);
        check("rst_state", 32'(bus.state_dbg), 32'(IDLE));

        // Table of single operations with latency, busy and hold checks
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            launch(vecs[i].q, vecs[i].b, vecs[i].r, vecs[i].exp, 1'b0);
            wait_done(lat);
            check("latency", 32'(lat), 32'(W));
            check("busy_in_done", 32'(bus.busy), 32'd1);
            @(negedge clk);
            check("busy_after", 32'(bus.busy), 32'd0);
            check("done_after", 32'(bus.done), 32'd0);
            repeat (3) @(negedge clk);
            check("P_hold", 32'(bus.P), 32'(vecs[i].exp));
        end

        // Back-to-back with start held high: one op every W+2 cycles
        @(negedge clk);
        prev_t = 0;
        for (int i = 0; i < 3; i++) begin
            launch(b2b[i].q, b2b[i].b, b2b[i].r, b2b[i].exp, i < 2);
            if (i > 0) check("b2b_interval", 32'((accept_t - prev_t) / 10), 32'(W + 2));
            prev_t = accept_t;
        end
        wait_done(lat);
        @(negedge clk);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // start pulses and operand changes during RUN are ignored
        @(negedge clk);
        launch(7'd7, 7'd7, 7'd1, 14'd50, 1'b0);
        dc = done_cnt;
        for (int i = 1; i <= W; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("busy_run", 32'(bus.busy), 32'd1);
            if (i < W) begin
                check("no_early_done", 32'(bus.done), 32'd0);
                bus.start = 1'($urandom_range(0, 1));
                bus.Q_in  = 7'($urandom_range(0, 127));
                bus.B_in  = 7'($urandom_range(0, 127));
                bus.R_in  = 7'($urandom_range(0, 127));
            end else begin
                check("done_on_time", 32'(bus.done), 32'd1);
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        check("busy_drop", 32'(bus.busy), 32'd0);
        repeat (10) @(negedge clk);
        check("single_done", 32'(done_cnt - dc), 32'd1);
        check("P_interf", 32'(bus.P), 32'd50);

        // Reset in the 3rd RUN cycle aborts without a done pulse
        launch(7'd100, 7'd100, 7'd0, 14'd10000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        dc = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", 32'(bus.state_dbg), 32'(IDLE));
        check("abort_P",     32'(bus.P), 32'd0);
        check("abort_busy",  32'(bus.busy), 32'd0);
        check("abort_done",  32'(bus.done), 32'd0);
        repeat (12) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dc), 32'd0);
        launch(7'd9, 7'd9, 7'd0, 14'd81, 1'b0);
        wait_done(lat);
        check("latency_after_abort", 32'(lat), 32'(W));

        // Rebuild dividends from quotient/divisor/remainder
        for (int i = 0; i < 400; i++) begin
            if (i == 0) begin
                a = 127; bb = 1;
            end else if (i == 1) begin
                a = 0; bb = 127;
            end else if (i == 2) begin
                a = 126; bb = 127;
            end else begin
                a  = $urandom_range(0, 127);
                bb = $urandom_range(1, 127);
            end
            @(negedge clk);
            launch(7'(a / bb), 7'(bb), 7'(a % bb), 14'(a), 1'b0);
            wait_done(lat);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_add_secuencial.md
Name: mult_add_secuencial

Overview:
- Sequential shift-add multiplier-accumulator that computes P = Q·B + R. It is the inverse datapath of divisor_restoring: it rebuilds a dividend from quotient, divisor and remainder.
- Used in the divider's self-check path and as a standalone arithmetic unit.
- Same start/done handshake style as the divider; one multiplier bit is processed per clock.

Parameters:
- W, 7, operand width in bits for Q_in, B_in and R_in. Legal range 2..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- Q_in  in  W  multiplier operand (quotient).
- B_in  in  W  multiplicand operand (divisor).
- R_in  in  W  addend (remainder).
- P  out  2W  result Q·B+R. Registered; holds its value until the next accepted start.
- busy  out  1  high while a computation is in progress (RUN or DONE).
- done  out  1  single-cycle pulse; result valid on P.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high; all state is updated on the rising edge of clk.
- Reset values: state=IDLE, P=0, busy=0, done=0, counter=0, all internal registers 0.
- State machine has three states: IDLE → RUN → DONE → IDLE.
- IDLE:
  - If start=1 at edge k: latch q_reg=Q_in and b_sh={W'0,B_in}, set acc={W'0,R_in}, cnt=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - If q_reg[0]=1: acc += b_sh (2W-bit add).
  - Then b_sh <<= 1, q_reg >>= 1, cnt++.
  - On the edge where cnt==W-1: move to DONE, load P with the final acc, assert done.
- DONE: done=1 for exactly one cycle (edges k+W to k+W+1). At the next edge, return to IDLE with done=0.
- Latency: done is high in the cycle that starts at edge k+W. Throughput is one operation per W+2 cycles.
- No early termination: the cycle count is fixed and independent of the data.
- Width and overflow: the maximum result is (2^W−1)² + 2^W−1 = 2^2W − 2^W, so it fits in 2W bits. The accumulator never overflows.
- start while busy=1 (RUN or DONE): ignored. The current operation is not disturbed and operands are not re-latched.
- start held high continuously: a new operation is accepted in the first IDLE cycle after DONE.
- Input stability: changes on Q_in, B_in or R_in after acceptance have no effect.
- Q_in=0 or B_in=0: still runs the full W cycles; P=R_in.
- Reset mid-operation: at the next edge, abort immediately to the reset values. No done pulse is emitted and P reads 0.
- rst and start in the same cycle: rst wins.

Decomposition:
- Package mult_add_pkg:
  - state enum: IDLE, RUN, DONE.
  - width helper constant CNT_W = $clog2(W).
- No sub-module. The datapath (accumulator, shifter, counter) and the FSM live in one module of about 150 lines.

Test Plan:
- After reset: P=0, busy=0, done=0. Then Q=7, B=7, R=1, start → done exactly 7 cycles after the start edge, P=50.
- Back-to-back runs with start re-asserted immediately after each done, no idle gap:
  - (7,5,0) → 35
  - (7,8,7) → 63
  - (6,15,10) → 100
- Extremes:
  - (127,127,126) → P=16255; the top bit does not overflow.
  - (0,99,42) → P=42 after the full 7 cycles.
- start pulsed and operand inputs changed during RUN of (7,7,1) → P=50, exactly one done pulse, busy profile unchanged.
- rst asserted in the 3rd RUN cycle of (100,100,0) → next cycle state=IDLE, P=0, busy=0, no done pulse. A following (9,9,0) → 81.
- Self-check loop against divisor_restoring:
  - For every a in 0..127 and b in 1..127, run divisor_restoring, then feed (Q,b,R) → P==a.
